// File: rtl/aes_nios_debug_ocimem_ctrl.sv
// aes_nios_debug_ocimem_ctrl
// ---------------------------------------------------------------------------
// Debug-memory access engine for the Nios II OCI. It executes JTAG debug
// commands (address load, read, write) against a local debug RAM and returns
// read data on MonDReg for the next scan. The same RAM is also reachable from
// a CPU-side Avalon-MM slave port. JTAG always has priority over that port.
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   jdo[37:0]                   command/data word from the sysclk debug stage
//   take_action_ocimem_a        load MonAReg from jdo, optionally queue a read
//   take_no_action_ocimem_a     queue a read at MonAReg
//   take_action_ocimem_b        queue a full-word write of jdo[34:3] at MonAReg
//   avs_*                       Avalon-MM slave (word addressed, byte lanes)
//   MonDReg                     last JTAG read result
//   MonAReg                     current JTAG word address (auto-increments)
//   jtag_busy                   JTAG command pending or executing
//   ocimem_overrun              sticky: a JTAG strobe was dropped
// ---------------------------------------------------------------------------
module aes_nios_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_waitrequest,
  output logic [DATA_W-1:0]     MonDReg,
  output logic [ADDR_W-1:0]     MonAReg,
  output logic                  jtag_busy,
  output logic                  ocimem_overrun
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_J_RD,
    ST_J_CAP,
    ST_J_WR,
    ST_A_RD,
    ST_A_DONE
  } state_t;

  state_t              state_reg;
  logic                slot_valid_reg;
  logic                slot_is_wr_reg;
  logic [DATA_W-1:0]   slot_data_reg;
  logic [ADDR_W-1:0]   mon_a_reg;
  logic [DATA_W-1:0]   mon_d_reg;
  logic                overrun_reg;

  // Command requests. An action_a without the read bit only loads the
  // address, so it never competes for the slot.
  logic req_wr;
  logic req_rd_a;
  logic req_rd_n;
  logic any_req;
  logic multi_req;
  logic accept;
  logic drop;
  logic jtag_go;
  logic go_is_wr;
  logic avs_wr_ack;

  assign req_wr    = take_action_ocimem_b;
  assign req_rd_a  = take_action_ocimem_a & jdo[35];
  assign req_rd_n  = take_no_action_ocimem_a;
  assign any_req   = req_wr | req_rd_a | req_rd_n;
  assign multi_req = (req_wr & (req_rd_a | req_rd_n)) | (req_rd_a & req_rd_n);
  assign accept    = any_req & ~slot_valid_reg;
  assign drop      = (any_req & slot_valid_reg) | multi_req;

  // A strobe seen in IDLE is acted on straight away (bypassing the slot) so
  // the command's first state follows the strobe by one cycle.
  assign jtag_go  = slot_valid_reg | accept;
  assign go_is_wr = slot_valid_reg ? slot_is_wr_reg : req_wr;

  // Avalon write is zero-wait only in IDLE with no JTAG work and no read.
  assign avs_wr_ack = (state_reg == ST_IDLE) & ~jtag_go & ~avs_read &
                      avs_write & ~reset;

  assign avs_waitrequest = reset | ~((state_reg == ST_A_DONE) | avs_wr_ack);

  // ---------------------------------------------------------------- RAM ---
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [NUM_LANES-1:0]  ram_be;
  logic [DATA_W-1:0]     ram_q;

  assign ram_we    = ~reset & ((state_reg == ST_J_WR) | avs_wr_ack);
  assign ram_addr  = ((state_reg == ST_A_RD) | avs_wr_ack) ? avs_address : mon_a_reg;
  assign ram_wdata = (state_reg == ST_J_WR) ? slot_data_reg : avs_writedata;
  assign ram_be    = (state_reg == ST_J_WR) ? {NUM_LANES{1'b1}} : avs_byteenable;

  // One byte-wide array per lane keeps each lane a plain single-writer RAM.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_q_reg;

    always_ff @(posedge clk) begin
      if (ram_we && ram_be[gi]) begin
        lane_mem[ram_addr] <= ram_wdata[gi*8 +: 8];
      end
      lane_q_reg <= lane_mem[ram_addr];
    end

    assign ram_q[gi*8 +: 8] = lane_q_reg;
  end

  // ---------------------------------------------------------- control ---
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      slot_valid_reg <= 1'b0;
      slot_is_wr_reg <= 1'b0;
      slot_data_reg  <= '0;
      mon_a_reg      <= '0;
      mon_d_reg      <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      if (accept) begin
        slot_valid_reg <= 1'b1;
        slot_is_wr_reg <= req_wr;
        slot_data_reg  <= jdo[34:3];
      end

      // A drop in the same cycle as a clear request leaves the flag set.
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (take_action_ocimem_a && jdo[25]) begin
        overrun_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (jtag_go) begin
            state_reg <= go_is_wr ? ST_J_WR : ST_J_RD;
          end else if (avs_read) begin
            state_reg <= ST_A_RD;
          end
        end
        ST_J_RD:  state_reg <= ST_J_CAP;
        ST_J_CAP: begin
          mon_d_reg      <= ram_q;
          slot_valid_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        ST_J_WR: begin
          slot_valid_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        ST_A_RD:   state_reg <= ST_A_DONE;
        ST_A_DONE: state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase

      // An explicit address load overrides the post-access increment.
      if (take_action_ocimem_a) begin
        mon_a_reg <= jdo[ADDR_W+25:26];
      end else if ((state_reg == ST_J_CAP) || (state_reg == ST_J_WR)) begin
        mon_a_reg <= mon_a_reg + 1'b1;
      end
    end
  end

  assign avs_readdata   = ((state_reg == ST_A_DONE) && !reset) ? ram_q : '0;
  assign MonDReg        = mon_d_reg;
  assign MonAReg        = mon_a_reg;
  assign ocimem_overrun = overrun_reg;
  assign jtag_busy      = slot_valid_reg | (state_reg == ST_J_RD) |
                          (state_reg == ST_J_CAP) | (state_reg == ST_J_WR);

  // jdo bits that carry nothing for this engine.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

endmodule
